hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RV64 core. It sits beside the ID/EX pipeline register and drives that register's write and flush side. It also drives the IF/ID and EX/MEM registers and the PC. It detects load-use hazards, taken-branch redirects resolved in MEM, and data-memory busy freezes, and it asserts the stall, bubble and flush controls that every pipeline register consumes. It also keeps saturating event counters for performance debug.

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl_sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FREEZE   = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

  localparam int CNT_W_DEF = 32;

  localparam logic [4:0] X0 = 5'd0;

  function automatic logic src_hit(
    input logic       uses,
    input logic [4:0] rs,
    input logic [4:0] rd
  );
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard detection inputs and pipeline-register control outputs.
interface hazard_ctrl_if;

  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       mem_branch_taken;
  logic       dmem_busy;

  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       pc_src;

  modport master (
    input  id_valid, id_rs1, id_rs2,
    input  id_uses_rs1, id_uses_rs2,
    input  ex_mem_read, ex_rd,
    input  mem_branch_taken, dmem_busy,
    output pc_write, if_id_write, if_id_flush,
    output id_ex_write, id_ex_flush,
    output ex_mem_flush, pc_src
  );

  modport slave (
    output id_valid, id_rs1, id_rs2,
    output id_uses_rs1, id_uses_rs2,
    output ex_mem_read, ex_rd,
    output mem_branch_taken, dmem_busy,
    input  pc_write, if_id_write, if_id_flush,
    input  id_ex_write, id_ex_flush,
    input  ex_mem_flush, pc_src
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch redirect and dmem freeze control
// for the IF/ID, ID/EX and EX/MEM registers plus the PC.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.master    hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  hz_state_t state_q;
  hz_state_t state_d;
  hz_state_t mode;
  logic      pend_q;
  logic      pend_d;

  logic load_use;
  logic stall_inc;
  logic flush_inc;
  logic frz_inc;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_write;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic pc_src;

  assign load_use = hz.id_valid
                  & hz.ex_mem_read
                  & (hz.ex_rd != X0)
                  & (src_hit(hz.id_uses_rs1, hz.id_rs1, hz.ex_rd)
                  |  src_hit(hz.id_uses_rs2, hz.id_rs2, hz.ex_rd));

  // A released freeze resumes whatever it interrupted in the same cycle.
  always_comb begin
    mode = state_q;
    if (state_q == FREEZE) begin
      mode = pend_q ? REDIRECT : RUN;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_src       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    frz_inc      = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
      pend_d       = 1'b0;
    end else if (hz.dmem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      state_d     = FREEZE;
      pend_d      = (mode == REDIRECT);
      frz_inc     = 1'b1;
    end else begin
      unique case (mode)
        REDIRECT: begin
          if_id_flush = 1'b1;
          state_d     = RUN;
          pend_d      = 1'b0;
        end
        RUN: begin
          state_d = RUN;
          pend_d  = 1'b0;
          if (hz.mem_branch_taken) begin
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = REDIRECT;
            flush_inc    = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_write  = id_ex_write;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.pc_src       = pc_src;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (frz_inc),
    .count (freeze_cnt)
  );

endmodule
